// File: rtl/watch_mode_ctrl_if.sv
// Button levels in, mode/stopwatch/time-set commands and digit blanking out.
// The controller takes the slave view; the debouncers and datapaths take the master view.
interface watch_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_a;
  logic       btn_b;
  logic [1:0] mode;
  logic       sw_run;
  logic       sw_clear;
  logic       hr_inc;
  logic       hr_dec;
  logic       min_inc;
  logic       min_dec;
  logic [3:0] blank;

  modport master (
    output btn_mode, btn_a, btn_b,
    input  mode, sw_run, sw_clear, hr_inc, hr_dec, min_inc, min_dec, blank
  );

  modport slave (
    input  btn_mode, btn_a, btn_b,
    output mode, sw_run, sw_clear, hr_inc, hr_dec, min_inc, min_dec, blank
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Wristwatch mode controller: mode sequencing, stopwatch run/clear, time-set
// pulses with auto-repeat, idle timeout back to CLOCK, and set-field blinking.
module watch_mode_ctrl #(
  parameter int unsigned BLINK_HALF   = 25_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned TIMEOUT      = 500_000_000,
  parameter int unsigned CW           = 32
) (
  input  logic             uclock,
  input  logic             rst_n,
  watch_mode_ctrl_if.slave bus
);

  localparam logic [1:0] ST_CLOCK     = 2'd0;
  localparam logic [1:0] ST_STOPWATCH = 2'd1;
  localparam logic [1:0] ST_SET_HR    = 2'd2;
  localparam logic [1:0] ST_SET_MIN   = 2'd3;

  localparam logic [3:0] BLANK_HR  = 4'b1100;
  localparam logic [3:0] BLANK_MIN = 4'b0011;

  localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] HOLD_FIRST  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] HOLD_NEXT   = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] IDLE_LIMIT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  // Registered state
  logic          prev_mode_q, prev_a_q, prev_b_q;
  logic [1:0]    state_q;
  logic          run_q;
  logic          clear_q;
  logic          hr_inc_q, hr_dec_q, min_inc_q, min_dec_q;
  logic [3:0]    blank_q;
  logic [CW-1:0] hold_q;
  logic          repeating_q;
  logic [CW-1:0] idle_q;
  logic [CW-1:0] blink_q;
  logic          phase_q;

  // Next-state values
  logic [1:0]    state_d;
  logic          run_d;
  logic          clear_d;
  logic          hr_inc_d, hr_dec_d, min_inc_d, min_dec_d;
  logic [3:0]    blank_d;
  logic [CW-1:0] hold_d;
  logic          repeating_d;
  logic [CW-1:0] idle_d;
  logic [CW-1:0] blink_d;
  logic          phase_d;

  // Combinational helpers
  logic          rise_mode_c, rise_a_c, rise_b_c;
  logic          in_set_c;
  logic          timeout_c;
  logic          mode_change_c;
  logic          single_btn_c;
  logic          set_btn_c;
  logic          inc_c, dec_c;
  logic [CW-1:0] hold_thr_c;

  // A press is a low-to-high transition of the debounced level
  assign rise_mode_c = bus.btn_mode & ~prev_mode_q;
  assign rise_a_c    = bus.btn_a & ~prev_a_q;
  assign rise_b_c    = bus.btn_b & ~prev_b_q;

  assign in_set_c     = state_q[1];
  assign single_btn_c = bus.btn_a ^ bus.btn_b;
  assign set_btn_c    = bus.btn_a | bus.btn_b;
  assign timeout_c    = in_set_c && (idle_q == IDLE_LIMIT);
  assign hold_thr_c   = repeating_q ? HOLD_NEXT : HOLD_FIRST;

  // State and output registers
  always_ff @(posedge uclock or negedge rst_n) begin
    if (!rst_n) begin
      prev_mode_q <= 1'b1;
      prev_a_q    <= 1'b1;
      prev_b_q    <= 1'b1;
      state_q     <= ST_CLOCK;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
      hr_inc_q    <= 1'b0;
      hr_dec_q    <= 1'b0;
      min_inc_q   <= 1'b0;
      min_dec_q   <= 1'b0;
      blank_q     <= 4'b0000;
      hold_q      <= '0;
      repeating_q <= 1'b0;
      idle_q      <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
    end else begin
      prev_mode_q <= bus.btn_mode;
      prev_a_q    <= bus.btn_a;
      prev_b_q    <= bus.btn_b;
      state_q     <= state_d;
      run_q       <= run_d;
      clear_q     <= clear_d;
      hr_inc_q    <= hr_inc_d;
      hr_dec_q    <= hr_dec_d;
      min_inc_q   <= min_inc_d;
      min_dec_q   <= min_dec_d;
      blank_q     <= blank_d;
      hold_q      <= hold_d;
      repeating_q <= repeating_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    clear_d       = 1'b0;
    hr_inc_d      = 1'b0;
    hr_dec_d      = 1'b0;
    min_inc_d     = 1'b0;
    min_dec_d     = 1'b0;
    blank_d       = 4'b0000;
    hold_d        = '0;
    repeating_d   = 1'b0;
    idle_d        = '0;
    blink_d       = blink_q;
    phase_d       = phase_q;
    inc_c         = 1'b0;
    dec_c         = 1'b0;
    mode_change_c = 1'b0;

    // A mode press outranks the idle timeout
    if (rise_mode_c) begin
      state_d = state_q + 2'd1;
    end else if (timeout_c) begin
      state_d = ST_CLOCK;
    end
    mode_change_c = (state_d != state_q);

    // Idle counter only advances in a set mode with every button released
    if (in_set_c && !timeout_c && !rise_mode_c && !rise_a_c && !rise_b_c &&
        !bus.btn_mode && !set_btn_c) begin
      idle_d = idle_q + CNT_ONE;
    end

    // Stopwatch: a toggles run, b clears only while stopped
    if (state_q == ST_STOPWATCH && !rise_mode_c) begin
      if (rise_a_c) begin
        run_d = ~run_q;
      end else if (rise_b_c && !run_q) begin
        clear_d = 1'b1;
      end
    end

    // Time set: first pulse on the press, then delayed auto-repeat
    if (in_set_c && !mode_change_c) begin
      if ((rise_a_c && !bus.btn_b) || (rise_b_c && !bus.btn_a)) begin
        inc_c       = rise_a_c;
        dec_c       = rise_b_c;
        hold_d      = CNT_ONE;
        repeating_d = 1'b0;
      end else if (hold_q != '0 && single_btn_c) begin
        if (hold_q == hold_thr_c) begin
          inc_c       = bus.btn_a;
          dec_c       = bus.btn_b;
          hold_d      = CNT_ONE;
          repeating_d = 1'b1;
        end else begin
          hold_d      = hold_q + CNT_ONE;
          repeating_d = repeating_q;
        end
      end
    end

    hr_inc_d  = (state_q == ST_SET_HR)  && inc_c;
    hr_dec_d  = (state_q == ST_SET_HR)  && dec_c;
    min_inc_d = (state_q == ST_SET_MIN) && inc_c;
    min_dec_d = (state_q == ST_SET_MIN) && dec_c;

    // Blink phase restarts visible on every mode change
    if (mode_change_c) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + CNT_ONE;
    end

    // Keep the field readable while a set button is held
    if (state_d[1] && phase_d && !set_btn_c) begin
      blank_d = (state_d == ST_SET_HR) ? BLANK_HR : BLANK_MIN;
    end
  end

  assign bus.mode     = state_q;
  assign bus.sw_run   = run_q;
  assign bus.sw_clear = clear_q;
  assign bus.hr_inc   = hr_inc_q;
  assign bus.hr_dec   = hr_dec_q;
  assign bus.min_inc  = min_inc_q;
  assign bus.min_dec  = min_dec_q;
  assign bus.blank    = blank_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: a rule-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_watch_mode_ctrl;

  localparam int BH = 4;
  localparam int RD = 8;
  localparam int RR = 3;
  localparam int TO = 40;

  logic uclock = 1'b0;
  logic rst_n;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (edge index based)
  int       cyc, last_act, ent, h_start, m_mode;
  bit       h_valid, m_run, pm, pa, pb;
  bit [4:0] m_pul;
  bit [3:0] m_blank;

  // Pulse monitors
  int cnt_clr, cnt_hi, cnt_hd, cnt_mi, cnt_md;
  int q_hi[$];

  watch_mode_ctrl_if bus_if();

  watch_mode_ctrl #(
    .BLINK_HALF  (BH),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .TIMEOUT     (TO),
    .CW          (32)
  ) dut (
    .uclock(uclock),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 uclock = ~uclock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    cyc = 0; last_act = 0; ent = 0; h_start = 0; h_valid = 0;
    m_mode = 0; m_run = 0; pm = 1; pa = 1; pb = 1;
    m_pul = '0; m_blank = '0;
  endtask

  task automatic model_step();
    bit rm, ra, rb, inc, dec, tmo, a, b;
    int nm, d;
    a   = bus_if.btn_a;
    b   = bus_if.btn_b;
    cyc = cyc + 1;
    rm  = bus_if.btn_mode && !pm;
    ra  = a && !pa;
    rb  = b && !pb;
    tmo = (m_mode >= 2) && (cyc - last_act == TO + 1);
    nm  = rm ? (m_mode + 1) % 4 : (tmo ? 0 : m_mode);
    m_pul = '0;
    inc = 0;
    dec = 0;
    if (!rm && m_mode == 1) begin
      if (ra) m_run = !m_run;
      else if (rb && !m_run) m_pul[4] = 1'b1;
    end
    if (!rm && nm == m_mode && m_mode >= 2) begin
      if ((ra && !b) || (rb && !a)) begin
        inc = ra; dec = rb; h_valid = 1; h_start = cyc;
      end else if (h_valid && (a != b)) begin
        d = cyc - h_start;
        if (d == RD || (d > RD && (d - RD) % RR == 0)) begin
          inc = a; dec = b;
        end
      end else begin
        h_valid = 0;
      end
    end else begin
      h_valid = 0;
    end
    if (m_mode == 2) begin m_pul[3] = inc; m_pul[2] = dec; end
    if (m_mode == 3) begin m_pul[1] = inc; m_pul[0] = dec; end
    if (rm || ra || rb || bus_if.btn_mode || a || b || m_mode < 2 || tmo) last_act = cyc;
    if (nm != m_mode) ent = cyc;
    m_blank = '0;
    if (nm >= 2 && ((cyc - ent) / BH) % 2 == 1 && !(a || b))
      m_blank = (nm == 2) ? 4'b1100 : 4'b0011;
    m_mode = nm;
    pm = bus_if.btn_mode;
    pa = a;
    pb = b;
  endtask

  task automatic model_loop();
    forever begin
      @(posedge uclock or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge uclock);
      chk("mode", int'(bus_if.mode), m_mode);
      chk("sw_run", int'(bus_if.sw_run), int'(m_run));
      chk("pulses", int'({bus_if.sw_clear, bus_if.hr_inc, bus_if.hr_dec,
                          bus_if.min_inc, bus_if.min_dec}), int'(m_pul));
      chk("blank", int'(bus_if.blank), int'(m_blank));
      if (bus_if.sw_clear) cnt_clr++;
      if (bus_if.hr_inc) begin cnt_hi++; q_hi.push_back(cyc); end
      if (bus_if.hr_dec) cnt_hd++;
      if (bus_if.min_inc) cnt_mi++;
      if (bus_if.min_dec) cnt_md++;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge uclock);
      #1;
    end
  endtask

  task automatic press_mode();
    bus_if.btn_mode = 1'b1; step();
    bus_if.btn_mode = 1'b0; step();
  endtask

  task automatic press_a();
    bus_if.btn_a = 1'b1; step();
    bus_if.btn_a = 1'b0; step();
  endtask

  task automatic press_b();
    bus_if.btn_b = 1'b1; step();
    bus_if.btn_b = 1'b0; step();
  endtask

  initial begin
    int exp_steps[4];
    int exp_off[5];
    int base, idx0, snap, snap2, n_on, n_bad, entry, exitc;
    exp_steps = '{1, 2, 3, 0};
    exp_off   = '{0, 8, 11, 14, 17};

    rst_n = 1'b1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_a    = 1'b1;
    bus_if.btn_b    = 1'b0;
    cnt_clr = 0; cnt_hi = 0; cnt_hd = 0; cnt_mi = 0; cnt_md = 0;
    model_reset();
    fork
      model_loop();
      compare_loop();
      begin
        #100000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
      end
    join_none
    #1 rst_n = 1'b0;

    // Reset with btn_a held through release
    step(3);
    chk("reset mode", int'(bus_if.mode), 0);
    chk("reset sw_run", int'(bus_if.sw_run), 0);
    chk("reset blank", int'(bus_if.blank), 0);
    rst_n = 1'b1;
    step(3);
    bus_if.btn_a = 1'b0;
    step();
    chk("no pulses after reset", cnt_clr + cnt_hi + cnt_hd + cnt_mi + cnt_md, 0);

    // Four mode presses walk the full cycle
    for (int i = 0; i < 4; i++) begin
      press_mode();
      chk("mode step", int'(bus_if.mode), exp_steps[i]);
      chk("model mode step", m_mode, exp_steps[i]);
    end

    // Stopwatch run/clear rules
    press_mode();
    press_a();
    chk("sw_run after start", int'(bus_if.sw_run), 1);
    snap = cnt_clr;
    press_b();
    chk("no clear while running", cnt_clr - snap, 0);
    press_a();
    chk("sw_run after stop", int'(bus_if.sw_run), 0);
    press_b();
    chk("clear pulse width", cnt_clr - snap, 1);
    press_a();
    press_mode(); press_mode(); press_mode();
    chk("back in CLOCK", int'(bus_if.mode), 0);
    chk("sw_run persists", int'(bus_if.sw_run), 1);

    // SET_HR auto-repeat while btn_a held for 20 cycles
    press_mode(); press_mode();
    chk("in SET_HR", int'(bus_if.mode), 2);
    idx0 = q_hi.size();
    base = cyc + 1;
    bus_if.btn_a = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.blank != 4'b0000) n_bad++;
    end
    bus_if.btn_a = 1'b0;
    chk("blank while held", n_bad, 0);
    chk("hr_inc count", q_hi.size() - idx0, 5);
    for (int i = 0; i < 5; i++) begin
      if (idx0 + i < q_hi.size()) chk("hr_inc offset", q_hi[idx0 + i] - base, exp_off[i]);
      else chk("hr_inc offset", -1, exp_off[i]);
    end
    n_on = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus_if.blank == 4'b1100) n_on++;
      else if (bus_if.blank != 4'b0000) n_bad++;
    end
    chk("blink blanked samples", n_on, 8);
    chk("blink illegal patterns", n_bad, 0);

    // SET_MIN idle timeout
    snap  = cnt_mi;
    snap2 = cnt_md;
    bus_if.btn_mode = 1'b1;
    step();
    entry = cyc;
    bus_if.btn_mode = 1'b0;
    chk("in SET_MIN", int'(bus_if.mode), 3);
    exitc = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus_if.mode == 2'd0) begin
        exitc = cyc;
        break;
      end
    end
    chk("timeout edges", exitc - entry, 41);
    chk("no min pulses", (cnt_mi - snap) + (cnt_md - snap2), 0);
    chk("blank after timeout", int'(bus_if.blank), 0);

    // Simultaneous presses
    press_mode();
    chk("in STOPWATCH", int'(bus_if.mode), 1);
    snap = cnt_hi;
    bus_if.btn_mode = 1'b1;
    bus_if.btn_a    = 1'b1;
    step();
    bus_if.btn_mode = 1'b0;
    bus_if.btn_a    = 1'b0;
    step();
    chk("mode wins", int'(bus_if.mode), 2);
    chk("sw_run unchanged", int'(bus_if.sw_run), 1);
    chk("no hr_inc on mode press", cnt_hi - snap, 0);
    snap2 = cnt_hd;
    bus_if.btn_a = 1'b1;
    bus_if.btn_b = 1'b1;
    step(3);
    bus_if.btn_a = 1'b0;
    bus_if.btn_b = 1'b0;
    step(2);
    chk("a+b no pulses", (cnt_hi - snap) + (cnt_hd - snap2), 0);
    press_b();
    chk("hr_dec single", cnt_hd - snap2, 1);

    // Async reset mid-repeat in SET_MIN
    press_mode();
    chk("in SET_MIN again", int'(bus_if.mode), 3);
    snap = cnt_mi;
    bus_if.btn_a = 1'b1;
    step(12);
    chk("min_inc repeats", cnt_mi - snap, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset mode", int'(bus_if.mode), 0);
    chk("async reset sw_run", int'(bus_if.sw_run), 0);
    chk("async reset blank", int'(bus_if.blank), 0);
    chk("async reset pulses", int'({bus_if.min_inc, bus_if.min_dec, bus_if.hr_inc}), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    bus_if.btn_a = 1'b0;
    step(3);
    chk("final mode", int'(bus_if.mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
- Central mode controller for the wristwatch.
- Turns the debounced button levels into mode sequencing, stopwatch run/clear commands, and time-set increment/decrement pulses.
- Drives per-digit blanking so the field being set blinks on the 4-digit display.
- Sits between the debouncers and the clock, stopwatch and display-mux datapaths. It replaces the direct switch-based mode selection.

Parameters:
BLINK_HALF, 25_000_000, cycles per blink half-period (0.5 s at 50 MHz)
REPEAT_DELAY, 25_000_000, cycles a set button is held before auto-repeat starts
REPEAT_RATE, 5_000_000, cycles between auto-repeat pulses
TIMEOUT, 500_000_000, idle cycles in a set mode before returning to CLOCK
CW, 32, width of internal counters; must hold each value above

Ports:
uclock  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  debounced level, mode button
btn_a  input  1  debounced level, start/stop or increment
btn_b  input  1  debounced level, clear or decrement
mode  output  2  0=CLOCK, 1=STOPWATCH, 2=SET_HR, 3=SET_MIN
sw_run  output  1  stopwatch count enable (level)
sw_clear  output  1  one-cycle stopwatch clear pulse
hr_inc, hr_dec  output  1 each  one-cycle hour adjust pulses
min_inc, min_dec  output  1 each  one-cycle minute adjust pulses
blank  output  4  1 = blank digit; bit3 = leftmost (hour tens)

Behaviour:
- Interface: one clock, uclock; reset rst_n is asynchronous, active-low.
- Reset values:
  - mode=CLOCK; sw_run=0; all pulses=0; blank=4'b0000.
  - All counters 0.
  - Edge-detect history registers reset to 1, so a button held through reset produces no edge.
- Edge detection:
  - rise_x = btn_x & ~prev_x, evaluated at each edge.
  - Every pulse output is registered: high for exactly one cycle, starting at the clock edge where the rise is sampled.
- Mode FSM:
  - rise_mode advances CLOCK→STOPWATCH→SET_HR→SET_MIN→CLOCK.
  - Priority: if rise_mode coincides with rise_a or rise_b, the mode advance wins and a/b are ignored that cycle.
- CLOCK: a and b are ignored; no pulses.
- STOPWATCH:
  - rise_a toggles sw_run.
  - rise_b pulses sw_clear only when sw_run=0; ignored while running.
  - rise_a and rise_b in the same cycle: toggle only, no clear.
- sw_run persists through other modes (stopwatch runs in the background). Only rise_a in STOPWATCH or reset changes it.
- SET_HR / SET_MIN:
  - rise_a pulses hr_inc (SET_HR) or min_inc (SET_MIN); rise_b pulses the matching dec.
  - a and b both high in the same cycle: no pulse, and the hold counter clears.
- Auto-repeat:
  - Applies while exactly one of a/b stays high in a set mode.
  - The hold counter counts from the rise. REPEAT_DELAY cycles after the first pulse, a repeat pulse is issued; further repeats follow every REPEAT_RATE cycles.
  - Release, or a mode change, clears the hold counter.
- Timeout:
  - The idle counter resets on any rise or while any button is high.
  - It increments in SET_HR/SET_MIN otherwise; it is held at 0 in CLOCK/STOPWATCH.
  - On reaching TIMEOUT, mode becomes CLOCK on the next edge and the counter clears.
- Blink:
  - Free-running phase toggles every BLINK_HALF cycles; the phase counter resets on every mode change, so the first half-period is visible.
  - Blank phase: in SET_HR, blank=4'b1100; in SET_MIN, blank=4'b0011.
  - While a set button is high, blank=0 so the value is readable during repeat.
  - blank=0 in CLOCK/STOPWATCH.
- Pulse outputs are never high in a mode other than the one that owns them. The pulse and mode change register on the same edge.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously), including sw_run.

Test Plan:
- Bench parameters for all scenarios: BLINK_HALF=4, REPEAT_DELAY=8, REPEAT_RATE=3, TIMEOUT=40.
- Hold btn_a high across rst_n release, then four btn_mode presses → no pulses after reset; mode steps 1,2,3,0, one step per press.
- STOPWATCH: press a → sw_run=1; press b → no sw_clear; press a → sw_run=0; press b → sw_clear high exactly 1 cycle; go to CLOCK → sw_run unchanged.
- SET_HR: hold btn_a 20 cycles → hr_inc at rise cycle, then at +8, +11, +14, +17 (5 pulses total); blank=0 while held; release → blank alternates 1100/0000 every 4 cycles.
- SET_MIN with no buttons: mode returns to 0 exactly 41 edges after entry; min_inc/min_dec never asserted; blank returns to 0.
- Simultaneous: btn_mode and btn_a rise on the same cycle in STOPWATCH → mode=2, sw_run unchanged, no hr_inc. btn_a and btn_b rise together in SET_HR → no pulses.
- Assert rst_n low mid-repeat in SET_MIN while sw_run=1 → mode=0, sw_run=0, blank=0 without waiting for a clock edge.
